layer_fade_ctrl: RTL and testbench
==================================

// Module: layer_fade_ctrl
// PURPOSE
//  Per-layer fade sequencer feeding the layer compositor's enable/transparency lists.
//  Turns a level "layer wanted on" request per layer into a frame-synchronous fade-in /
//  fade-out ramp of transparency codes. Codes: 0=1/4, 1=1/8, 2=1/16, 3=1/32, >=4 hidden.
//  All output changes occur only on frame boundaries, so no tearing within a frame.
// PARAMETERS
//  LAYERNUM     4  number of layers; width of all list ports
//  STEP_FRAMES  8  frame-start pulses per transparency step (legal range >=1)
// PORTS
//  i_clk          in   1             system clock; single clock domain
//  i_rst          in   1             synchronous reset, active-high
//  i_frame_start  in   1             one-cycle pulse at start of vertical blank
//  i_req_on       in   LAYERNUM      level request per layer: 1=show, 0=hide
//  i_freeze       in   1             (only with LAYER_FADE_FREEZE_EN) stall all fading
//  o_enableList   out  LAYERNUM      per-layer enable to compositor
//  o_transList    out  LAYERNUM x 3  per-layer transparency code to compositor
//  o_busy         out  1             1 while any layer is in FADE_IN or FADE_OUT
// BEHAVIOUR
//  Reset: every layer OFF; o_enableList=0; every o_transList entry=3'd7; o_busy=0;
//    frame divider=0. Reset wins over all other inputs, including mid-fade.
//  Frame divider: counter 0..STEP_FRAMES-1, width $clog2(STEP_FRAMES) (min 1 bit).
//    Advances only on cycles with i_frame_start=1.
//    "tick" = i_frame_start && counter==STEP_FRAMES-1; counter wraps to 0 on tick.
//    STEP_FRAMES=1: every frame_start is a tick.
//  Per-layer FSM, state and 2-bit level L. Registers update only on tick; i_req_on sampled on tick.
//    OFF:      req=1 -> FADE_IN, L=3.                  req=0 -> stay.
//    FADE_IN:  req=1 -> L-1; when L reaches 0 -> ON.   req=0 -> FADE_OUT, L+1 (L=3 -> OFF).
//    ON:       req=0 -> FADE_OUT, L=1.                 req=1 -> stay, L=0.
//    FADE_OUT: req=0 -> L+1; at L=3 next tick -> OFF.  req=1 -> FADE_IN, L-1 (L=0 -> ON).
//  Reversal reverses from the current level; no level is skipped or repeated.
//  Layers are fully independent; simultaneous opposite requests cause no interaction.
//  Outputs are registered, 1-cycle latency after the tick edge.
//    OFF: enable=0, trans=3'd7.  Otherwise: enable=1, trans={1'b0,L}.
//  o_busy: registered OR over layers of (state==FADE_IN || state==FADE_OUT).
//  Full ramp OFF->ON = 4 ticks; ON->OFF = 4 ticks (levels 1,2,3 then OFF).
//  Request glitches between ticks are ignored; only the value at the tick is used.
// CONFIGURATION
//  LAYER_FADE_FREEZE_EN defined: i_freeze port exists.
//    While i_freeze=1: divider holds (frame_start ignored), no ticks, FSMs and outputs hold.
//    On release, counting resumes from the held counter value.
//  LAYER_FADE_FREEZE_EN undefined: no i_freeze port; behaviour as if i_freeze=0.
// TESTING  (LAYERNUM=4, STEP_FRAMES=2 unless noted)
//  1 Reset: i_rst=1 for 2 clk -> enable=4'b0000, all trans=7, busy=0;
//    frame_starts with req=0 -> no change.
//  2 Fade-in: req[0]=1 held. Frame_start #2 -> en[0]=1, trans[0]=3, busy=1.
//    #4,#6,#8 -> trans 2,1,0; busy=0 after #8.
//  3 Reversal: req[1]=1 until trans[1]=2, then req[1]=0.
//    Next ticks -> trans 3, then en[1]=0/trans 7.
//  4 Independence: layer2 ON, layer3 OFF; flip both requests together.
//    Per tick: L2 trans 1,2,3,off; L3 trans 3,2,1,0.
//  5 Reset mid-fade: assert i_rst while layers at L=1 and L=2 -> next edge all OFF, trans 7,
//    divider 0; first tick after release is at frame_start #2.
//  6 Freeze (macro on, STEP_FRAMES=1): i_freeze=1 over 3 frame_starts -> outputs constant;
//    release -> next frame_start advances one level.

Source files
------------

// File: rtl/layer_fade_ctrl.sv
// layer_fade_ctrl: per-layer fade sequencer for the layer compositor.
// Converts a level "layer wanted on" request per layer into a frame-synchronous
// fade-in / fade-out ramp of transparency codes (0=1/4 .. 3=1/32, 7=hidden).
// A frame divider produces one "tick" every STEP_FRAMES frame-start pulses; all
// layer state advances only on ticks, so outputs never change mid-frame.
// Optional feature macro: LAYER_FADE_FREEZE_EN adds i_freeze, which stalls the
// divider and every layer while high.
module layer_fade_ctrl #(
    parameter int LAYERNUM    = 4,
    parameter int STEP_FRAMES = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_frame_start,
    input  logic [LAYERNUM-1:0]      i_req_on,
`ifdef LAYER_FADE_FREEZE_EN
    input  logic                     i_freeze,
`endif
    output logic [LAYERNUM-1:0]      o_enableList,
    output logic [LAYERNUM-1:0][2:0] o_transList,
    output logic                     o_busy
);

    localparam int              DIV_W    = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_FRAMES - 1);

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        FADE_IN  = 2'd1,
        ON       = 2'd2,
        FADE_OUT = 2'd3
    } fade_state_e;

    logic             frame_en;
    logic             tick;
    logic [DIV_W-1:0] div_q;

    fade_state_e state_q [LAYERNUM];
    fade_state_e state_d [LAYERNUM];
    logic [1:0]  lvl_q   [LAYERNUM];
    logic [1:0]  lvl_d   [LAYERNUM];
    logic        busy_d;

`ifdef LAYER_FADE_FREEZE_EN
    // Frozen frames are invisible to the divider, so counting resumes where it stopped.
    assign frame_en = i_frame_start & ~i_freeze;
`else
    assign frame_en = i_frame_start;
`endif

    assign tick = frame_en && (div_q == DIV_LAST);

    // Frame divider: counts frame starts, wraps to zero on the tick.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples
        // pre-edge values; blocking here would create order-dependent simulation.
        if (i_rst) begin
            div_q <= '0;
        end else if (frame_en) begin
            div_q <= tick ? '0 : div_q + DIV_W'(1);
        end
    end

    // Per-layer next state/level; reversals continue from the current level.
    always_comb begin
        // NOTE: defaults first, so every path assigns every bit and no latch is inferred.
        state_d = state_q;
        lvl_d   = lvl_q;
        for (int i = 0; i < LAYERNUM; i++) begin
            unique case (state_q[i])
                OFF: begin
                    if (i_req_on[i]) begin
                        state_d[i] = FADE_IN;
                        lvl_d[i]   = 2'd3;
                    end
                end
                FADE_IN: begin
                    if (i_req_on[i]) begin
                        if (lvl_q[i] <= 2'd1) begin
                            state_d[i] = ON;
                            lvl_d[i]   = 2'd0;
                        end else begin
                            lvl_d[i] = lvl_q[i] - 2'd1;
                        end
                    end else if (lvl_q[i] == 2'd3) begin
                        state_d[i] = OFF;
                    end else begin
                        state_d[i] = FADE_OUT;
                        lvl_d[i]   = lvl_q[i] + 2'd1;
                    end
                end
                ON: begin
                    if (i_req_on[i]) begin
                        lvl_d[i] = 2'd0;
                    end else begin
                        state_d[i] = FADE_OUT;
                        lvl_d[i]   = 2'd1;
                    end
                end
                FADE_OUT: begin
                    if (!i_req_on[i]) begin
                        if (lvl_q[i] == 2'd3) begin
                            state_d[i] = OFF;
                        end else begin
                            lvl_d[i] = lvl_q[i] + 2'd1;
                        end
                    end else if (lvl_q[i] <= 2'd1) begin
                        state_d[i] = ON;
                        lvl_d[i]   = 2'd0;
                    end else begin
                        state_d[i] = FADE_IN;
                        lvl_d[i]   = lvl_q[i] - 2'd1;
                    end
                end
            endcase
        end
    end

    // Layer state registers: reset to OFF, advance only on ticks.
    always_ff @(posedge i_clk) begin
        // NOTE: the per-layer arrays are small control state, so every entry is
        // reset explicitly; a reset loop like this is not a RAM and maps to flops.
        if (i_rst) begin
            for (int i = 0; i < LAYERNUM; i++) begin
                state_q[i] <= OFF;
                lvl_q[i]   <= 2'd3;
            end
        end else if (tick) begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
        end
    end

    // Busy when any layer is mid-ramp.
    always_comb begin
        busy_d = 1'b0;
        for (int i = 0; i < LAYERNUM; i++) begin
            if (state_q[i] == FADE_IN || state_q[i] == FADE_OUT) begin
                busy_d = 1'b1;
            end
        end
    end

    // Registered compositor outputs derived from layer state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_enableList <= '0;
            o_transList  <= '1;
            o_busy       <= 1'b0;
        end else begin
            for (int i = 0; i < LAYERNUM; i++) begin
                if (state_q[i] == OFF) begin
                    o_enableList[i] <= 1'b0;
                    o_transList[i]  <= 3'd7;
                end else begin
                    o_enableList[i] <= 1'b1;
                    o_transList[i]  <= {1'b0, lvl_q[i]};
                end
            end
            o_busy <= busy_d;
        end
    end

endmodule

// File: tb/tb_layer_fade_ctrl.sv
// tb_layer_fade_ctrl: directed stimulus for layer_fade_ctrl (LAYERNUM=4,
// STEP_FRAMES=2) with a scoreboard queue of hand-computed expected outputs
// consumed by an independent monitor. With LAYER_FADE_FREEZE_EN defined a second
// instance (STEP_FRAMES=1) exercises the freeze input.
module tb_layer_fade_ctrl;

    typedef struct {
        logic [3:0]      en;
        logic [3:0][2:0] tr;
        logic            busy;
        bit              sel;
        string           name;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            frame_start;
    logic [3:0]      req;
    logic [3:0]      en;
    logic [3:0][2:0] trans;
    logic            busy;

    exp_t            exp_q [$];
    exp_t            e;
    int              checks = 0;
    int              errors = 0;

    logic [3:0]      c_en;
    logic [3:0][2:0] c_tr;
    logic            c_busy;

    always #5 clk = ~clk;

`ifdef LAYER_FADE_FREEZE_EN
    logic            freeze;
    logic [3:0]      req_f;
    logic [3:0]      en_f;
    logic [3:0][2:0] trans_f;
    logic            busy_f;
`endif

    layer_fade_ctrl #(.LAYERNUM(4), .STEP_FRAMES(2)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_frame_start (frame_start),
        .i_req_on      (req),
`ifdef LAYER_FADE_FREEZE_EN
        .i_freeze      (1'b0),
`endif
        .o_enableList  (en),
        .o_transList   (trans),
        .o_busy        (busy)
    );

`ifdef LAYER_FADE_FREEZE_EN
    layer_fade_ctrl #(.LAYERNUM(4), .STEP_FRAMES(1)) dut_f (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_frame_start (frame_start),
        .i_req_on      (req_f),
        .i_freeze      (freeze),
        .o_enableList  (en_f),
        .o_transList   (trans_f),
        .o_busy        (busy_f)
    );
`endif

    // Monitor: compares every queued expectation against the DUT outputs.
    always @(negedge clk) begin
        logic [3:0]      g_en;
        logic [3:0][2:0] g_tr;
        logic            g_busy;
        while (exp_q.size() > 0) begin
            e      = exp_q.pop_front();
            g_en   = en;
            g_tr   = trans;
            g_busy = busy;
`ifdef LAYER_FADE_FREEZE_EN
            if (e.sel) begin
                g_en   = en_f;
                g_tr   = trans_f;
                g_busy = busy_f;
            end
`endif
            checks++;
            if (g_en !== e.en || g_tr !== e.tr || g_busy !== e.busy) begin
                errors++;
                $display("FAIL %s: got en=%b trans=%o busy=%b, required en=%b trans=%o busy=%b",
                         e.name, g_en, g_tr, g_busy, e.en, e.tr, e.busy);
            end
        end
    end

    task automatic set_exp(input logic [3:0] x_en, input logic [2:0] t3, input logic [2:0] t2,
                           input logic [2:0] t1, input logic [2:0] t0, input logic x_busy);
        c_en   = x_en;
        c_tr   = {t3, t2, t1, t0};
        c_busy = x_busy;
    endtask

    task automatic expect_now(input string name);
        exp_t x;
        x.en   = c_en;
        x.tr   = c_tr;
        x.busy = c_busy;
        x.sel  = 1'b0;
        x.name = name;
        exp_q.push_back(x);
    endtask

    // One frame-start pulse followed by enough settle time for registered outputs.
    task automatic frame_pulse();
        @(posedge clk); #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic frm(input string name);
        frame_pulse();
        expect_now(name);
    endtask

    // Two frames (one tick at STEP_FRAMES=2): no change after the first.
    task automatic tick(input string name, input logic [3:0] x_en, input logic [2:0] t3,
                        input logic [2:0] t2, input logic [2:0] t1, input logic [2:0] t0,
                        input logic x_busy);
        frm({name, "_hold"});
        set_exp(x_en, t3, t2, t1, t0, x_busy);
        frm(name);
    endtask

`ifdef LAYER_FADE_FREEZE_EN
    task automatic expect_f(input string name, input logic [2:0] t0, input logic x_busy);
        exp_t x;
        x.en   = 4'b0001;
        x.tr   = {3'd7, 3'd7, 3'd7, t0};
        x.busy = x_busy;
        x.sel  = 1'b1;
        x.name = name;
        exp_q.push_back(x);
    endtask
`endif

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        req         = 4'b0000;
`ifdef LAYER_FADE_FREEZE_EN
        freeze      = 1'b0;
        req_f       = 4'b0000;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        set_exp(4'b0000, 7, 7, 7, 7, 0);
        repeat (2) @(posedge clk);
        #1 expect_now("reset");

        // Idle frames with no request: nothing moves.
        frm("idle_f1");
        frm("idle_f2");

        // Fade-in of layer 0, with a request glitch across a non-tick frame.
        req = 4'b0001;
        tick("fin_L3", 4'b0001, 7, 7, 7, 3, 1);
        req = 4'b0000;
        frm("glitch_hold");
        req = 4'b0001;
        set_exp(4'b0001, 7, 7, 7, 2, 1);
        frm("fin_L2");
        tick("fin_L1", 4'b0001, 7, 7, 7, 1, 1);
        tick("fin_on", 4'b0001, 7, 7, 7, 0, 0);

        // Reversal of layer 1 at level 2.
        req = 4'b0011;
        tick("rev_L3", 4'b0011, 7, 7, 3, 0, 1);
        tick("rev_L2", 4'b0011, 7, 7, 2, 0, 1);
        req = 4'b0001;
        tick("rev_back_L3", 4'b0011, 7, 7, 3, 0, 1);
        tick("rev_off", 4'b0001, 7, 7, 7, 0, 0);

        // Independence: bring layer 2 on, then swap layers 2 and 3 together.
        req = 4'b0101;
        tick("l2_L3", 4'b0101, 7, 3, 7, 0, 1);
        tick("l2_L2", 4'b0101, 7, 2, 7, 0, 1);
        tick("l2_L1", 4'b0101, 7, 1, 7, 0, 1);
        tick("l2_on", 4'b0101, 7, 0, 7, 0, 0);
        req = 4'b1001;
        tick("swap_1", 4'b1101, 3, 1, 7, 0, 1);
        tick("swap_2", 4'b1101, 2, 2, 7, 0, 1);
        tick("swap_3", 4'b1101, 1, 3, 7, 0, 1);
        tick("swap_4", 4'b1001, 0, 7, 7, 0, 0);

        // Reset mid-fade: layers 0/3 at levels 1/2, divider part-way.
        req = 4'b0001;
        tick("mid_a", 4'b1001, 1, 7, 7, 0, 1);
        req = 4'b0000;
        tick("mid_b", 4'b1001, 2, 7, 7, 1, 1);
        frm("mid_hold");
        @(posedge clk); #1 rst = 1'b1; frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        set_exp(4'b0000, 7, 7, 7, 7, 0);
        repeat (2) @(posedge clk);
        #1 expect_now("rst_mid");
        req = 4'b0001;
        frm("post_rst_f1");
        set_exp(4'b0001, 7, 7, 7, 3, 1);
        frm("post_rst_tick");

`ifdef LAYER_FADE_FREEZE_EN
        // Freeze on the STEP_FRAMES=1 instance.
        req_f = 4'b0001;
        frame_pulse();
        expect_f("frz_start", 3, 1);
        freeze = 1'b1;
        for (int k = 0; k < 3; k++) begin
            frame_pulse();
            expect_f("frz_hold", 3, 1);
        end
        freeze = 1'b0;
        frame_pulse();
        expect_f("frz_release", 2, 1);
`endif

        repeat (5) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
